// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin AXI read arbiter with burst-length checking
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          m_arvalid,
  input  logic [2*ADDR_W-1:0] m_araddr,
  input  logic [7:0]          m_arlen,
  input  logic [5:0]          m_arsize,
  input  logic [3:0]          m_arburst,
  output logic [1:0]          m_arready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          m_rresp,
  output logic                m_rlast,
  output logic [1:0]          m_rvalid,
  input  logic [1:0]          m_rready,
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [3:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic                gnt,
  output logic                busy,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e              state_q;
  logic                gnt_q;
  logic                prio_q;
  logic                len_err_q;
  logic [3:0]          beat_cnt_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [3:0]          arlen_q;
  logic [2:0]          arsize_q;
  logic [1:0]          arburst_q;
  logic                win_d;
  logic                beat_ok;

  // Single requester wins outright; under contention the priority pointer decides.
  always_comb begin
    win_d = prio_q;
    if (m_arvalid == 2'b01) win_d = 1'b0;
    else if (m_arvalid == 2'b10) win_d = 1'b1;
  end

  assign beat_ok = (state_q == DATA) && s_rvalid && s_rready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      len_err_q  <= 1'b0;
      beat_cnt_q <= 4'd0;
      araddr_q   <= '0;
      arlen_q    <= 4'd0;
      arsize_q   <= 3'd0;
      arburst_q  <= 2'd0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|m_arvalid) begin
            gnt_q     <= win_d;
            araddr_q  <= win_d ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
            arlen_q   <= win_d ? m_arlen[7:4]   : m_arlen[3:0];
            arsize_q  <= win_d ? m_arsize[5:3]  : m_arsize[2:0];
            arburst_q <= win_d ? m_arburst[3:2] : m_arburst[1:0];
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            beat_cnt_q <= 4'd0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            if (beat_cnt_q != 4'hF) beat_cnt_q <= beat_cnt_q + 4'd1;
            if (s_rlast) begin
              len_err_q <= (beat_cnt_q != arlen_q);
              prio_q    <= ~gnt_q;
              state_q   <= IDLE;
            end else if (beat_cnt_q == arlen_q) begin
              // Overrun: flag it but keep forwarding until the bridge ends the burst.
              len_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_arvalid = (state_q == ADDR);
  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arsize  = arsize_q;
  assign s_arburst = arburst_q;
  assign m_arready = (s_arvalid && s_arready) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

  assign s_rready  = (state_q == DATA) && m_rready[gnt_q];
  assign m_rvalid  = ((state_q == DATA) && s_rvalid) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    m_arvalid;
  logic [2*AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [5:0]    m_arsize;
  logic [3:0]    m_arburst;
  logic [1:0]    m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic [1:0]    m_rvalid;
  logic [1:0]    m_rready;
  logic          s_arvalid;
  logic [AW-1:0] s_araddr;
  logic [3:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          s_rvalid;
  logic          s_rready;
  logic          gnt;
  logic          busy;
  logic          len_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .gnt(gnt), .busy(busy), .len_err(len_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one bridge beat, check the forwarded copy, then clock it through.
  task automatic beat(input string tag, input logic [1:0] exp_mv, input logic [31:0] d,
                      input logic [1:0] resp, input logic last);
    s_rvalid = 1'b1; s_rdata = d; s_rresp = resp; s_rlast = last;
    #1;
    check({tag, "_mvalid"}, 64'(m_rvalid), 64'(exp_mv));
    check({tag, "_rdata"},  64'(m_rdata),  64'(d));
    check({tag, "_rresp"},  64'(m_rresp),  64'(resp));
    check({tag, "_rlast"},  64'(m_rlast),  64'(last));
    tick;
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_gnt_vec;
    int bi;
    logic rr;

    resetn = 1'b0; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_arburst = '0; m_rready = '0; s_arready = 1'b0; s_rdata = '0; s_rresp = '0;
    s_rlast = 1'b0; s_rvalid = 1'b0;
    tick; tick;
    check("rst_busy", 64'(busy), 0);
    check("rst_gnt", 64'(gnt), 0);
    check("rst_s_arvalid", 64'(s_arvalid), 0);
    check("rst_s_rready", 64'(s_rready), 0);
    check("rst_m_rvalid", 64'(m_rvalid), 0);
    check("rst_m_arready", 64'(m_arready), 0);
    check("rst_len_err", 64'(len_err), 0);
    resetn = 1'b1;
    tick;

    // Single request from master 0, 4-beat burst
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h10; m_arlen = 8'h03;
    m_arsize = 6'd2; m_arburst = 4'd1; s_arready = 1'b1; m_rready = 2'b11;
    #1;
    check("t1_idle_arvalid", 64'(s_arvalid), 0);
    check("t1_idle_arready", 64'(m_arready), 0);
    tick;
    check("t1_s_arvalid", 64'(s_arvalid), 1);
    check("t1_s_araddr", 64'(s_araddr), 64'h10);
    check("t1_s_arlen", 64'(s_arlen), 3);
    check("t1_s_arsize", 64'(s_arsize), 2);
    check("t1_s_arburst", 64'(s_arburst), 1);
    check("t1_gnt", 64'(gnt), 0);
    check("t1_busy", 64'(busy), 1);
    check("t1_m_arready", 64'(m_arready), 64'h1);
    m_arvalid = 2'b00;
    tick;
    check("t1_arready_once", 64'(m_arready), 0);
    for (int b = 0; b < 4; b++) begin
      beat("t1_beat", 2'b01, 32'hA0 + 32'(b), 2'(b), (b == 3));
      check("t1_len_err", 64'(len_err), 0);
    end
    check("t1_done_busy", 64'(busy), 0);
    check("t1_done_gnt", 64'(gnt), 0);

    // Contention with early R data held high: grants must alternate from master 0
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    m_arlen = 8'h00; m_araddr = {32'h200, 32'h100}; m_arvalid = 2'b11;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h55; s_arready = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      exp_gnt_vec = (k % 2 == 1) ? 2'b10 : 2'b01;
      check("rr_gnt", 64'(gnt), 64'(k % 2));
      check("rr_araddr", 64'(s_araddr), (k % 2 == 1) ? 64'h200 : 64'h100);
      check("rr_addr_busy", 64'(busy), 1);
      check("rr_early_mvalid", 64'(m_rvalid), 0);
      check("rr_early_srready", 64'(s_rready), 0);
      check("rr_m_arready", 64'(m_arready), 64'(exp_gnt_vec));
      tick;
      check("rr_data_mvalid", 64'(m_rvalid), 64'(exp_gnt_vec));
      check("rr_data_srready", 64'(s_rready), 1);
      tick;
      check("rr_idle_gap", 64'(busy), 0);
      check("rr_idle_gnt_hold", 64'(gnt), 64'(k % 2));
      if (k == 3) begin
        m_arvalid = 2'b00; s_rvalid = 1'b0; s_rlast = 1'b0;
      end
      tick;
    end
    check("rr_end_idle", 64'(busy), 0);

    // Backpressure: AR stalled 5 cycles, then master 1 R ready toggling
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h300; m_arlen = 8'h20;
    m_arsize = 6'o30; m_arburst = 4'b1000; s_arready = 1'b0;
    tick;
    m_arvalid = 2'b00; m_araddr[63:32] = 32'hDEAD0000; m_arlen = 8'hF0;
    m_arsize = 6'o70; m_arburst = 4'b1100;
    for (int c = 0; c < 5; c++) begin
      check("bp_s_arvalid", 64'(s_arvalid), 1);
      check("bp_s_araddr", 64'(s_araddr), 64'h300);
      check("bp_s_arlen", 64'(s_arlen), 2);
      check("bp_s_arsize", 64'(s_arsize), 3);
      check("bp_s_arburst", 64'(s_arburst), 2);
      check("bp_m_arready", 64'(m_arready), 0);
      check("bp_gnt", 64'(gnt), 1);
      tick;
    end
    s_arready = 1'b1;
    #1;
    check("bp_m_arready_hs", 64'(m_arready), 64'h2);
    tick;
    s_arready = 1'b0;
    bi = 0;
    for (int c = 0; c < 6; c++) begin
      rr = (c % 2 == 1);
      m_rready = {rr, 1'b1};
      s_rvalid = 1'b1; s_rdata = 32'hB0 + 32'(bi); s_rresp = 2'b00; s_rlast = (bi == 2);
      #1;
      check("bp_s_rready", 64'(s_rready), 64'(rr));
      check("bp_m_rvalid", 64'(m_rvalid), 64'h2);
      check("bp_m_rdata", 64'(m_rdata), 64'hB0 + 64'(bi));
      tick;
      check("bp_len_err", 64'(len_err), 0);
      check("bp_busy", 64'(busy), (c == 5) ? 64'h0 : 64'h1);
      if (rr) bi++;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b11;

    // Early RLAST: arlen=3, last on beat 2
    m_arvalid = 2'b01; m_arlen = 8'h03; s_arready = 1'b1;
    tick;
    m_arvalid = 2'b00;
    tick;
    beat("la1", 2'b01, 32'hC0, 2'b00, 1'b0);
    check("la1_len_err", 64'(len_err), 0);
    beat("la2", 2'b01, 32'hC1, 2'b10, 1'b1);
    check("la2_len_err", 64'(len_err), 1);
    check("la2_idle", 64'(busy), 0);
    tick;
    check("la_pulse_one_cycle", 64'(len_err), 0);

    // Overrun: arlen=1, last on beat 4; error at beat 2, all beats forwarded
    m_arvalid = 2'b01; m_arlen = 8'h01;
    tick;
    m_arvalid = 2'b00;
    tick;
    beat("lb1", 2'b01, 32'hD0, 2'b00, 1'b0);
    check("lb1_len_err", 64'(len_err), 0);
    beat("lb2", 2'b01, 32'hD1, 2'b00, 1'b0);
    check("lb2_len_err", 64'(len_err), 1);
    beat("lb3", 2'b01, 32'hD2, 2'b00, 1'b0);
    check("lb3_len_err", 64'(len_err), 0);
    check("lb3_busy", 64'(busy), 1);
    beat("lb4", 2'b01, 32'hD3, 2'b00, 1'b1);
    check("lb4_idle", 64'(busy), 0);

    // Reset during beat 2 of 4; priority pointer was 1 before reset
    m_arvalid = 2'b01; m_arlen = 8'h03;
    tick;
    m_arvalid = 2'b00;
    tick;
    beat("rs1", 2'b01, 32'hE0, 2'b00, 1'b0);
    s_rvalid = 1'b1; s_rdata = 32'hE1; resetn = 1'b0;
    tick;
    check("rs_busy", 64'(busy), 0);
    check("rs_s_rready", 64'(s_rready), 0);
    check("rs_m_rvalid", 64'(m_rvalid), 0);
    check("rs_s_arvalid", 64'(s_arvalid), 0);
    check("rs_gnt", 64'(gnt), 0);
    check("rs_len_err", 64'(len_err), 0);
    resetn = 1'b1; s_rvalid = 1'b0;
    m_arvalid = 2'b11; m_araddr = {32'h700, 32'h600};
    tick;
    check("rs_prio_gnt", 64'(gnt), 0);
    check("rs_prio_addr", 64'(s_araddr), 64'h600);
    check("rs_prio_busy", 64'(busy), 1);
    m_arvalid = 2'b00;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master, one-slave read-channel arbiter for the AXI bridge.
- Shares the bridge read path (AR decode plus R data return) between two requesters, one transaction at a time.
- Round-robin grant. The grant is held from AR acceptance until the RLAST beat is accepted.
- Also counts R beats against ARLEN and flags burst-length protocol violations.

Parameters:
- ADDR_W, 32, address width of each AR channel
- DATA_W, 32, R data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clk
- m_arvalid  input  2  per-master AR valid (bit i = master i)
- m_araddr  input  2*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
- m_arlen  input  8  per-master burst length-1, 4 bits each
- m_arsize  input  6  per-master beat size, 3 bits each
- m_arburst  input  4  per-master burst type, 2 bits each
- m_arready  output  2  per-master AR ready
- m_rdata  output  DATA_W  R data, broadcast to both masters
- m_rresp  output  2  R response, broadcast to both masters
- m_rlast  output  1  R last, broadcast to both masters
- m_rvalid  output  2  per-master R valid, only the granted bit may be 1
- m_rready  input  2  per-master R ready
- s_arvalid, s_araddr, s_arlen[3:0], s_arsize[2:0], s_arburst[1:0]  output  AR channel to bridge
- s_arready  input  1  bridge AR ready
- s_rdata  input  DATA_W  bridge R data
- s_rresp  input  2  bridge R response
- s_rlast  input  1  bridge R last
- s_rvalid  input  1  bridge R valid
- s_rready  output  1  bridge R ready
- gnt  output  1  index of currently owning master, valid while busy=1
- busy  output  1  transaction in progress (ADDR or DATA state)
- len_err  output  1  one-cycle pulse on burst-length mismatch

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset (resetn=0 at a clk edge, any state, including mid-burst):
  - state=IDLE, prio=0, beat_cnt=0, gnt=0, busy=0, len_err=0
  - all valid and ready outputs 0
  - any in-flight transaction is abandoned; no response completes.
- IDLE:
  - If exactly one m_arvalid bit is set, that master wins.
  - If both are set, master prio wins.
  - Winner is registered into gnt. The winner's AR fields are latched into s_ar* registers. Next state is ADDR.
  - m_arready stays 0 in IDLE.
  - Latency: m_arvalid rises at edge n, so s_arvalid=1 after edge n+1.
- ADDR:
  - s_arvalid=1 with the latched fields, held stable until s_arready.
  - On the s_arvalid&s_arready edge: m_arready[gnt]=1 for exactly that cycle (combinational from s_arready, so the master sees the handshake in the same cycle). beat_cnt<=0, next state DATA.
  - The latched fields are unchanged while the master holds valid, per AXI rules.
- DATA:
  - m_rvalid[gnt]=s_rvalid; m_rvalid[~gnt]=0; s_rready=m_rready[gnt].
  - m_rdata, m_rresp and m_rlast pass through combinationally; zero added latency.
  - Each s_rvalid&s_rready beat increments beat_cnt (4-bit).
  - Beat with s_rlast=1:
    - If beat_cnt!=s_arlen, pulse len_err.
    - Next state IDLE; prio<=~gnt (the other master has priority next).
  - Beat with s_rlast=0 and beat_cnt==s_arlen (overrun):
    - Pulse len_err; keep forwarding until rlast.
    - beat_cnt saturates at 15.
- Outside DATA: s_rready=0 and m_rvalid=0. Bridge data arriving early is back-pressured, never dropped.
- A new arbitration happens only in IDLE. Minimum gap between transactions: 1 cycle (the IDLE cycle).
- A master's request lowered before grant is simply not seen. A request lowered after latch is still completed (protocol violation by the master, not checked).
- busy=1 in ADDR and DATA. gnt holds its value through IDLE until the next grant.
- No reordering, no outstanding transactions beyond one.

Test Plan:
- Single request:
  - Stimulus: m_arvalid=01, araddr0=0x10, arlen0=3, s_arready tied 1, bridge returns 4 beats with rlast on beat 4.
  - Required: s_arvalid 1 cycle after request; m_arready[0] pulses once; m_rvalid[0] 4 beats, m_rvalid[1]=0; len_err=0; back in IDLE.
- Contention round-robin:
  - Stimulus: m_arvalid=11 held continuously, arlen=0 each.
  - Required: grants alternate 0,1,0,1; every burst is separated by one IDLE cycle.
- Backpressure:
  - Stimulus: s_arready low for 5 cycles, then m_rready[gnt] toggling.
  - Required: s_ar* stable for the full 5 cycles; s_rready mirrors m_rready[gnt]; no beat is lost or duplicated.
- Length errors:
  - Stimulus: arlen=3 with rlast on beat 2.
  - Required: len_err pulses on beat 2, FSM returns to IDLE.
  - Stimulus: arlen=1 with rlast on beat 4.
  - Required: len_err pulses on beat 2, all 4 beats are forwarded.
- Reset mid-burst:
  - Stimulus: drop resetn during beat 2 of 4.
  - Required: next edge gives IDLE, busy=0, s_rready=0, prio=0; a subsequent m_arvalid=11 grants master 0.
- Early R data:
  - Stimulus: s_rvalid=1 during ADDR.
  - Required: s_rready=0 and m_rvalid=00 until state DATA.
